// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction scheduler and its helpers.
package i2c_pkg;

  localparam int DEF_NUM_REQ  = 2;
  localparam int DEF_ADDR_LEN = 7;
  localparam int DEF_DATA_LEN = 8;
  localparam int DEF_TIMEOUT  = 4096;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COMPLETE  = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

endpackage

// File: rtl/i2c_txn_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr, wrapping.
// Reusable for any shared I2C resource; gives one-hot and encoded winner.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    j   = 0;
    jj  = '0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Shares one I2C master between NUM_REQ requesters: round-robin grant, launch,
// completion tracking, and a watchdog that turns a hung master into err + sticky fault.
module i2c_txn_scheduler
  import i2c_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ADDR_LEN = DEF_ADDR_LEN,
  parameter int DATA_LEN = DEF_DATA_LEN,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]           req_rw,
  input  logic [NUM_REQ*2*DATA_LEN-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic                         err,
  output logic [2*DATA_LEN-1:0]        rdata,
  output logic                         fault,
  input  logic                         fault_clr,
  output logic                         m_start,
  output logic [ADDR_LEN-1:0]          m_add_reg,
  output logic                         m_R_W,
  output logic [DATA_LEN-1:0]          m_data_1,
  output logic [DATA_LEN-1:0]          m_data_2,
  input  logic                         m_free,
  input  logic [2*DATA_LEN-1:0]        m_rdata,
  output state_t                       dbg_state
);

  // Handshake: a requester holds req high until it sees its one-cycle done pulse;
  // gnt stays high from launch through the done cycle, and dropping req while
  // granted does not abort the transaction.

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t                state, state_nxt;
  logic [IW-1:0]         ptr, gnt_idx, ptr_nxt;
  logic [WW-1:0]         wdog;
  logic                  wdog_expired;
  logic                  free_q;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic [ADDR_LEN-1:0]   sel_addr;
  logic                  sel_rw;
  logic [2*DATA_LEN-1:0] sel_wdata;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_rw    = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  = req_addr[i*ADDR_LEN +: ADDR_LEN];
        sel_rw    = req_rw[i];
        sel_wdata = req_wdata[i*2*DATA_LEN +: 2*DATA_LEN];
      end
    end
  end

  assign wdog_expired = (wdog == WW'(TIMEOUT - 1));
  assign ptr_nxt      = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);

  // Busy/done tracking uses a flopped copy of m_free, so completion is judged
  // on a registered input and done lands two cycles after m_free rises.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!fault && m_free && arb_any) state_nxt = ST_LAUNCH;
      ST_LAUNCH:    state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!free_q)           state_nxt = ST_WAIT_DONE;
        else if (wdog_expired) state_nxt = ST_ERROR;
      end
      ST_WAIT_DONE: begin
        if (free_q)            state_nxt = ST_COMPLETE;
        else if (wdog_expired) state_nxt = ST_ERROR;
      end
      ST_COMPLETE:  state_nxt = ST_IDLE;
      ST_ERROR:     state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign m_start   = (state == ST_LAUNCH);
  assign err       = (state == ST_ERROR);
  assign done      = (state == ST_COMPLETE || state == ST_ERROR) ? gnt : '0;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      ptr       <= '0;
      wdog      <= '0;
      free_q    <= 1'b0;
      fault     <= 1'b0;
      rdata     <= '0;
      m_add_reg <= '0;
      m_R_W     <= 1'b0;
      m_data_1  <= '0;
      m_data_2  <= '0;
    end else begin
      state  <= state_nxt;
      free_q <= m_free;

      if (state == ST_LAUNCH || (state == ST_WAIT_BUSY && !free_q))
        wdog <= '0;
      else if ((state == ST_WAIT_BUSY || state == ST_WAIT_DONE) && wdog != WW'(TIMEOUT))
        wdog <= wdog + WW'(1);

      // A timeout beats a simultaneous clear.
      if (state == ST_ERROR)  fault <= 1'b1;
      else if (fault_clr)     fault <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_LAUNCH) begin
            gnt       <= arb_gnt;
            gnt_idx   <= arb_idx;
            m_add_reg <= sel_addr;
            m_R_W     <= sel_rw;
            m_data_1  <= sel_wdata[2*DATA_LEN-1:DATA_LEN];
            m_data_2  <= sel_wdata[DATA_LEN-1:0];
          end
        end
        ST_COMPLETE: begin
          gnt <= '0;
          ptr <= ptr_nxt;
          if (m_R_W) rdata <= m_rdata;
        end
        ST_ERROR: begin
          gnt <= '0;
          ptr <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Bench for i2c_txn_scheduler: vector table plus hand-written contention,
// reset, early-drop and timeout sequences against a small master model.
module tb_i2c_txn_scheduler;
  import i2c_pkg::*;

  localparam int NR  = 2;
  localparam int AL  = 7;
  localparam int DL  = 8;
  localparam int TO  = 16;
  localparam int SBW = NR + 1 + 2*DL;

  logic                clk, rst_n;
  logic [NR-1:0]       req;
  logic [NR*AL-1:0]    req_addr;
  logic [NR-1:0]       req_rw;
  logic [NR*2*DL-1:0]  req_wdata;
  logic [NR-1:0]       gnt, done;
  logic                err;
  logic [2*DL-1:0]     rdata;
  logic                fault, fault_clr, m_start;
  logic [AL-1:0]       m_add_reg;
  logic                m_R_W;
  logic [DL-1:0]       m_data_1, m_data_2;
  logic                m_free;
  logic [2*DL-1:0]     m_rdata;
  state_t              dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;
  logic [SBW-1:0] exp_q[$];

  logic        hang;
  logic [15:0] mdl_rdata, cur_rdata;
  int          mst, mcnt;

  typedef struct {
    logic [1:0]  req;
    logic        rw;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] mrd;
    logic [1:0]  exp_gnt;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t vecs[4];

  i2c_txn_scheduler #(.NUM_REQ(NR), .ADDR_LEN(AL), .DATA_LEN(DL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .fault(fault), .fault_clr(fault_clr), .m_start(m_start), .m_add_reg(m_add_reg),
    .m_R_W(m_R_W), .m_data_1(m_data_1), .m_data_2(m_data_2), .m_free(m_free),
    .m_rdata(m_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // master model: drops free the cycle after start is seen, raises it 3 cycles later
  initial begin
    m_free = 1'b1; m_rdata = '0; mst = 0; mcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mst = 0; m_free = 1'b1;
      end else begin
        case (mst)
          0: if (m_start && !hang) mst = 1;
          1: begin m_free = 1'b0; mst = 2; mcnt = 3; end
          default: begin
            if (mcnt > 1) mcnt--;
            else begin
              m_free = 1'b1; m_rdata = mdl_rdata; rise_cyc = cyc; mst = 0;
            end
          end
        endcase
      end
    end
  end

  // scoreboard monitor: {done, err, rdata after the done cycle}
  logic [NR-1:0]  mon_done;
  logic           mon_err;
  logic [SBW-1:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (done !== '0) begin
        mon_done = done;
        mon_err  = err;
        if (!mon_err) chk("done_latency", cyc - rise_cyc, 2);
        @(negedge clk);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done got=%b exp=none", mon_done);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("sb_done_err_rdata", {mon_done, mon_err, rdata}, mon_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (m_start) begin ok = 1'b1; break; end
    end
    chk("start_seen", ok, 1);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done !== '0) begin ok = 1'b1; break; end
    end
    chk("done_seen", ok, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_gnt"},     gnt, 0);
    chk({tag, "_done"},    {done, err, m_start}, 0);
    chk({tag, "_rdata"},   rdata, 0);
    chk({tag, "_fault"},   fault, 0);
    chk({tag, "_payload"}, {m_add_reg, m_R_W, m_data_1, m_data_2}, 0);
    chk({tag, "_state"},   dbg_state, ST_IDLE);
  endtask

  bit ok;
  int idx, n, t0;
  vec_t v;

  initial begin
    vecs[0] = '{req: 2'b01, rw: 1'b0, addr: 7'h50, wdata: 16'hA55A, mrd: 16'hDEAD, exp_gnt: 2'b01, exp_rdata: 16'h0000};
    vecs[1] = '{req: 2'b10, rw: 1'b1, addr: 7'h21, wdata: 16'h0000, mrd: 16'h1234, exp_gnt: 2'b10, exp_rdata: 16'h1234};
    vecs[2] = '{req: 2'b01, rw: 1'b1, addr: 7'h7F, wdata: 16'hFFFF, mrd: 16'hBEEF, exp_gnt: 2'b01, exp_rdata: 16'hBEEF};
    vecs[3] = '{req: 2'b10, rw: 1'b0, addr: 7'h00, wdata: 16'h1357, mrd: 16'h5555, exp_gnt: 2'b10, exp_rdata: 16'hBEEF};

    rst_n = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    fault_clr = 1'b0; hang = 1'b0; mdl_rdata = '0; cur_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven single transactions; the non-granted slot carries inverted payload
    for (int k = 0; k < 4; k++) begin
      v = vecs[k];
      idx = v.req[1] ? 1 : 0;
      req_addr  = {NR{~v.addr}};
      req_wdata = {NR{~v.wdata}};
      req_rw    = {NR{~v.rw}};
      req_addr[idx*AL +: AL]       = v.addr;
      req_wdata[idx*2*DL +: 2*DL]  = v.wdata;
      req_rw[idx]                  = v.rw;
      mdl_rdata = v.mrd;
      req = v.req;
      wait_start(ok);
      chk("vec_gnt", gnt, v.exp_gnt);
      chk("vec_addr", m_add_reg, v.addr);
      chk("vec_rw", m_R_W, v.rw);
      chk("vec_wdata", {m_data_1, m_data_2}, v.wdata);
      exp_q.push_back({v.exp_gnt, 1'b0, v.exp_rdata});
      @(posedge clk); #1;
      chk("start_one_cycle", m_start, 0);
      wait_done(ok);
      chk("payload_stable", {m_add_reg, m_R_W, m_data_1, m_data_2}, {v.addr, v.rw, v.wdata});
      chk("gnt_held_at_done", gnt, v.exp_gnt);
      req = '0;
      cur_rdata = v.exp_rdata;
    end

    // contention: both requesters held; grants alternate
    req_rw = '0;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_start(ok);
      chk("rr_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      exp_q.push_back({((k % 2 == 0) ? 2'b01 : 2'b10), 1'b0, cur_rdata});
      wait_done(ok);
    end
    req = '0;

    // early request drop
    req = 2'b01;
    wait_start(ok);
    chk("drop_gnt", gnt, 2'b01);
    req = '0;
    exp_q.push_back({2'b01, 1'b0, cur_rdata});
    wait_done(ok);

    // reset in WAIT_DONE; ptr points at 1 beforehand
    req = 2'b11;
    wait_start(ok);
    chk("pre_reset_gnt", gnt, 2'b10);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (dbg_state == ST_WAIT_DONE) begin ok = 1'b1; break; end
    end
    chk("reached_wait_done", ok, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midop_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur_rdata = '0;
    wait_start(ok);
    chk("post_reset_gnt", gnt, 2'b01);
    exp_q.push_back({2'b01, 1'b0, cur_rdata});
    wait_done(ok);
    req = '0;

    // timeout with a master that never goes busy; clear in the error cycle loses
    hang = 1'b1;
    req = 2'b01;
    wait_start(ok);
    t0 = cyc;
    exp_q.push_back({2'b01, 1'b1, cur_rdata});
    wait_done(ok);
    chk("timeout_err", err, 1);
    chk("timeout_latency", cyc - t0, TO + 1);
    fault_clr = 1'b1;
    req = '0;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    chk("fault_set_wins", fault, 1);
    chk("gnt_dropped_after_err", gnt, 0);
    req = 2'b01;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (m_start || gnt != '0) n++;
    end
    chk("blocked_while_fault", n, 0);
    hang = 1'b0;
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    chk("fault_cleared", fault, 0);
    wait_start(ok);
    chk("post_clear_gnt", gnt, 2'b01);
    exp_q.push_back({2'b01, 1'b0, cur_rdata});
    wait_done(ok);
    req = '0;

    repeat (6) @(posedge clk);
    #1;
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
